// File: rtl/rs485_half_duplex_ctrl_if.sv
// Bus-side signal bundle of the RS-485 half-duplex controller.
// master: the controller (drives grants, transmitter start and transceiver pins).
// slave : the surrounding requesters, transmitter and transceiver.
interface rs485_half_duplex_ctrl_if;
  logic       req0;
  logic [7:0] data0;
  logic       req1;
  logic [7:0] data1;
  logic       gnt0;
  logic       gnt1;
  logic       rx;
  logic       rdsig;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_wrsig;
  logic       de;
  logic       re_n;
  logic       busy;
  logic       collision;

  modport master (
    input  req0, data0, req1, data1, rx, rdsig, tx_busy,
    output gnt0, gnt1, tx_data, tx_wrsig, de, re_n, busy, collision
  );

  modport slave (
    output req0, data0, req1, data1, rx, rdsig, tx_busy,
    input  gnt0, gnt1, tx_data, tx_wrsig, de, re_n, busy, collision
  );
endinterface

// File: rtl/rs485_half_duplex_ctrl.sv
// Half-duplex RS-485 bus controller: waits for an idle bus, arbitrates
// round-robin between two byte requesters, drives DE/RE with guard times and
// issues one-cycle transmitter start pulses, with bursts of up to MAX_BURST.
// Optional feature macro: RS485_COLLISION_EN (abort on rx=0 during the pre-guard).
module rs485_half_duplex_ctrl #(
  parameter int unsigned GUARD_CLKS = 32,
  parameter int unsigned IDLE_CLKS  = 176,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  rs485_half_duplex_ctrl_if.master    bus
);

  localparam int unsigned GW = $clog2(GUARD_CLKS + 1);
  localparam int unsigned IW = $clog2(IDLE_CLKS + 1);
  localparam int unsigned BW = $clog2(MAX_BURST + 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_BUS   = 3'd1,
    S_GUARD_PRE  = 3'd2,
    S_LOAD       = 3'd3,
    S_SEND_START = 3'd4,
    S_SEND_WAIT  = 3'd5,
    S_GUARD_POST = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] guard_q, guard_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          sel_q, sel_d;
  logic          rr_last_q, rr_last_d;
  logic [IW-1:0] idle_q;

  logic          de_q, de_d;
  logic          gnt0_q, gnt0_d;
  logic          gnt1_q, gnt1_d;
  logic          wr_q, wr_d;
  logic          busy_q, busy_d;
  logic          coll_q, coll_d;
  logic [7:0]    txd_q, txd_d;

  logic          bus_free;
  logic          any_req;
  logic          arb_sel;
  logic          sel_req;
  logic          alt_req;
  logic          guard_done;
  logic          burst_ok;
  logic          collide;

  assign any_req    = bus.req0 | bus.req1;
  assign sel_req    = sel_q ? bus.req1 : bus.req0;
  assign alt_req    = sel_q ? bus.req0 : bus.req1;
  assign guard_done = (guard_q == GW'(GUARD_CLKS - 1));
  // Re-arbitration inside the post guard only follows a sent byte, never an abort.
  assign burst_ok   = (burst_q != '0) && (burst_q < BW'(MAX_BURST));
  assign bus_free   = (idle_q == IW'(IDLE_CLKS));

`ifdef RS485_COLLISION_EN
  assign collide = ~bus.rx;
`else
  assign collide = 1'b0;
`endif

  // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    arb_sel = 1'b0;
    if (bus.req0 && bus.req1) begin
      arb_sel = ~rr_last_q;
    end else if (bus.req1) begin
      arb_sel = 1'b1;
    end
  end

  // Bus-idle counter; held at zero while we drive, so it restarts when DE falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q <= '0;
    end else if (!bus.rx || bus.rdsig || de_q) begin
      idle_q <= '0;
    end else if (!bus_free) begin
      idle_q <= idle_q + IW'(1);
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      guard_q   <= '0;
      burst_q   <= '0;
      sel_q     <= 1'b0;
      rr_last_q <= 1'b1;
      de_q      <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      wr_q      <= 1'b0;
      busy_q    <= 1'b0;
      coll_q    <= 1'b0;
      txd_q     <= 8'h00;
    end else begin
      state_q   <= state_d;
      guard_q   <= guard_d;
      burst_q   <= burst_d;
      sel_q     <= sel_d;
      rr_last_q <= rr_last_d;
      de_q      <= de_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      wr_q      <= wr_d;
      busy_q    <= busy_d;
      coll_q    <= coll_d;
      txd_q     <= txd_d;
    end
  end

  // Next-state and counter update.
  always_comb begin
    state_d   = state_q;
    guard_d   = guard_q;
    burst_d   = burst_q;
    sel_d     = sel_q;
    rr_last_d = rr_last_q;
    unique case (state_q)
      S_IDLE: begin
        burst_d = '0;
        if (any_req) begin
          sel_d   = arb_sel;
          state_d = S_WAIT_BUS;
        end
      end
      S_WAIT_BUS: begin
        if (!sel_req) begin
          if (alt_req) begin
            sel_d = ~sel_q;
          end else begin
            state_d = S_IDLE;
          end
        end
        if ((sel_req || alt_req) && bus_free) begin
          state_d = S_GUARD_PRE;
          guard_d = '0;
        end
      end
      S_GUARD_PRE: begin
        guard_d = guard_q + GW'(1);
        if (!sel_req && !alt_req) begin
          state_d = S_GUARD_POST;
          guard_d = '0;
        end else begin
          if (!sel_req) begin
            sel_d = ~sel_q;
          end
          if (collide) begin
            state_d = S_GUARD_POST;
            guard_d = '0;
          end else if (guard_done) begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        burst_d   = burst_q + BW'(1);
        rr_last_d = sel_q;
        state_d   = S_SEND_START;
      end
      S_SEND_START: begin
        if (bus.tx_busy) begin
          state_d = S_SEND_WAIT;
        end
      end
      S_SEND_WAIT: begin
        if (!bus.tx_busy) begin
          state_d = S_GUARD_POST;
          guard_d = '0;
        end
      end
      S_GUARD_POST: begin
        guard_d = guard_q + GW'(1);
        if (any_req && burst_ok) begin
          sel_d   = arb_sel;
          state_d = S_LOAD;
        end else if (guard_done) begin
          burst_d = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output register inputs; the LOAD cycle is launched one clock later so
  // tx_wrsig lands GUARD_CLKS+1 clocks after DE rises.
  always_comb begin
    de_d   = (state_d == S_GUARD_PRE)  || (state_d == S_LOAD) ||
             (state_d == S_SEND_START) || (state_d == S_SEND_WAIT) ||
             (state_d == S_GUARD_POST);
    busy_d = (state_d != S_IDLE);
    wr_d   = (state_q == S_LOAD);
    gnt0_d = (state_q == S_LOAD) && !sel_q;
    gnt1_d = (state_q == S_LOAD) && sel_q;
    txd_d  = txd_q;
    if (state_q == S_LOAD) begin
      txd_d = sel_q ? bus.data1 : bus.data0;
    end
`ifdef RS485_COLLISION_EN
    coll_d = (state_q == S_GUARD_PRE) && (sel_req || alt_req) && collide;
`else
    coll_d = 1'b0;
`endif
  end

  assign bus.de        = de_q;
  assign bus.re_n      = de_q;
  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.tx_wrsig  = wr_q;
  assign bus.tx_data   = txd_q;
  assign bus.busy      = busy_q;
  assign bus.collision = coll_q;

endmodule

// File: doc/rs485_half_duplex_ctrl.md
Name: rs485_half_duplex_ctrl

Overview:
- Half-duplex RS-485 bus controller sitting between two byte requesters, the RS-485 transmitter and the transceiver's direction pins.
- Waits for the bus to be idle, arbitrates round-robin between the requesters, and drives DE/RE with guard times.
- Issues one-cycle start pulses to the transmitter and supports back-to-back bursts.
- Runs on the 16x-baud sample clock shared with the receiver.

Parameters:
GUARD_CLKS, 32, clocks DE is held before the first start bit and after the last stop bit (2 bit times at 16x).
IDLE_CLKS, 176, consecutive rx-high clocks (one full frame) before the bus counts as free.
MAX_BURST, 16, maximum bytes sent per bus ownership before DE must be released.

Ports:
clk  in  1  16x-baud sample clock
rst_n  in  1  asynchronous active-low reset
req0  in  1  requester 0 wants to send; held until gnt0
data0  in  8  requester 0 byte, stable while req0=1
req1  in  1  requester 1 wants to send; held until gnt1
data1  in  8  requester 1 byte, stable while req1=1
gnt0  out  1  one-cycle pulse: data0 consumed
gnt1  out  1  one-cycle pulse: data1 consumed
rx  in  1  raw bus line from transceiver RO
rdsig  in  1  receiver byte-valid pulse
tx_busy  in  1  transmitter shifting a frame
tx_data  out  8  byte to transmitter
tx_wrsig  out  1  one-cycle transmitter start pulse
de  out  1  transceiver driver enable
re_n  out  1  transceiver receiver enable (active low); always equals de
busy  out  1  controller state != IDLE
collision  out  1  one-cycle pulse on detected collision (feature only)

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: de=0, re_n=0, gnt0=0, gnt1=0, tx_wrsig=0, tx_data=8'h00, busy=0, collision=0. State=IDLE, all counters 0, rr_last=1 (req0 wins the first tie).
- Reset mid-frame: outputs drop immediately to reset values; DE releases asynchronously.
- Bus-idle counter:
  - Counts consecutive rx=1 cycles, saturating at IDLE_CLKS.
  - Clears to 0 when rx=0, rdsig=1, or de falls (1->0).
  - bus_free is true when the count equals IDLE_CLKS.
- Arbitration:
  - If only one req is high, that requester wins.
  - If both are high, the one not equal to rr_last wins.
  - rr_last updates on each gnt.
- States:
  - IDLE: on any req -> WAIT_BUS, selection recorded.
  - WAIT_BUS: de=0. When bus_free -> GUARD_PRE; de=1 from the next cycle; guard counter cleared.
  - GUARD_PRE: counts GUARD_CLKS cycles, then -> LOAD.
  - LOAD (1 cycle):
    - tx_data <= selected data; tx_wrsig=1; gnt of the selected requester=1; burst count +1.
    - -> SEND_START.
  - SEND_START: waits for tx_busy=1, then -> SEND_WAIT.
  - SEND_WAIT: waits for tx_busy=0, then -> GUARD_POST with guard counter cleared.
  - GUARD_POST:
    - If any req is high and burst count < MAX_BURST, re-arbitrate and go straight to LOAD on the next cycle. No bus wait, DE stays high.
    - Otherwise count GUARD_CLKS, then de=0, burst count=0, -> IDLE.
- Requester drop:
  - If the selected req falls before its gnt while in WAIT_BUS or GUARD_PRE, re-arbitrate the same cycle.
  - If no req remains: WAIT_BUS -> IDLE; GUARD_PRE -> GUARD_POST (de stays high for the full post guard).
- Latency: gnt and tx_wrsig are coincident. First tx_wrsig occurs exactly GUARD_CLKS+1 cycles after de rises.
- rx is ignored for idle detection while de=1, because the counter is cleared on de falling.

Optional Feature:
- Macro: RS485_COLLISION_EN.
- Defined:
  - In GUARD_PRE, rx sampled 0 -> abort.
  - No gnt and no tx_wrsig are issued; collision pulses for 1 cycle.
  - -> GUARD_POST, then IDLE. The request stays pending and retries after a fresh IDLE_CLKS.
- Undefined: collision is tied to 0 and rx is not checked in GUARD_PRE.

Test Plan:
- rx held high 200 clks, req0=1, data0=8'hA5 -> de rises; tx_wrsig and gnt0 pulse together 33 clks later with tx_data=8'hA5. After tx_busy falls, de falls 32 clks later.
- rx toggling low every 100 clks, req1=1 -> no de and no gnt1 until rx stays high for 176 consecutive clks.
- req0 and req1 both high with data0=8'h11, data1=8'h22 -> one ownership, gnt0 then gnt1, tx_data 8'h11 then 8'h22. de remains high between the two bytes.
- req0 held high continuously -> exactly 16 gnt0 pulses, then de=0 for at least 32 clks, then a new 176-clk idle wait.
- req0 raised then dropped after 10 clks in WAIT_BUS -> return to IDLE, de never asserted, no gnt0.
- RS485_COLLISION_EN defined, rx pulled low 5 clks into GUARD_PRE -> one collision pulse, no tx_wrsig, de drops after 32 clks; byte sent on retry.
